mask_frame_writer: RTL and testbench
====================================

Name: mask_frame_writer

Overview:
- Producer end of the binary mask frame buffer that the edge finder reads.
- Thresholds a streamed 8-bit intensity image, writes 1-bit mask pixels in row-major order (addr = y*WIDTH + x), and pulses a frame-complete trigger that drives the edge finder's find_corners_flag.
- Skips whole frames while the downstream reader reports busy, so the buffer is never overwritten mid-read.

Parameters:
- WIDTH, 240, pixels per line.
- HEIGHT, 320, lines per frame.
- ADDR_W, $clog2(WIDTH*HEIGHT), write address width (17 at defaults).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-low.
- pixel_valid_in  input  1  intensity_in valid this cycle.
- sof_in  input  1  start of frame; qualified by pixel_valid_in, marks the first pixel of a frame.
- intensity_in  input  8  pixel intensity.
- threshold_in  input  8  mask threshold, sampled at accepted sof.
- reader_busy_in  input  1  downstream edge finder busy.
- wr_addr_out  output  ADDR_W  frame buffer write address.
- wr_data_out  output  1  mask bit.
- wr_en_out  output  1  write strobe.
- frame_done_out  output  1  one-cycle pulse when a full frame has been written.
- busy_out  output  1  high in CAPTURE.
- dropped_frames_out  output  8  saturating count of frames skipped.

Behaviour:
- Reset (rst_in==0 at posedge):
  - All outputs 0; state IDLE; counters and latched threshold 0.
  - Reset mid-frame aborts the frame with no frame_done_out.
- Write latency: one cycle from an accepted pixel to wr_en_out=1 with its wr_addr_out/wr_data_out (all registered).
  - wr_en_out is 0 on every cycle not following an accepted pixel.
  - wr_addr_out and wr_data_out hold their last values while wr_en_out is 0.
- Mask rule: wr_data_out = (intensity_in >= latched threshold). Equality yields 1.
- States:
  - IDLE:
    - On pixel_valid_in && sof_in && !reader_busy_in: latch threshold_in, write this pixel at addr 0 (threshold compare uses the newly sampled threshold_in), set pixel count to 1, go to CAPTURE.
    - If reader_busy_in is high at that sof: increment dropped_frames_out (saturate at 255) and stay in IDLE.
    - Valid pixels without sof are ignored.
  - CAPTURE:
    - Each valid pixel is written at addr = count, then count increments.
    - The pixel with count == WIDTH*HEIGHT-1 is the last; transition to DONE.
    - reader_busy_in is ignored in CAPTURE.
    - pixel_valid_in && sof_in in CAPTURE (short frame) restarts the frame: relatch threshold, write at addr 0, count=1, no frame_done_out. If reader_busy_in is high at that sof, abort to IDLE and increment the drop count instead.
  - DONE:
    - frame_done_out asserted for exactly the one cycle in which the last pixel's write strobe is presented; return to IDLE next cycle.
    - An accepted sof in the cycle after DONE is accepted normally (back-to-back frames).
- Pixels presented with pixel_valid_in=0 never write.
- busy_out = (state == CAPTURE).
- The address counter never exceeds WIDTH*HEIGHT-1; there is no wrap within a frame.

Optional Feature:
- Macro MASK_PIXEL_COUNT_EN.
- Defined:
  - Adds output ones_count_out, width ADDR_W+1: number of mask-1 pixels written in the last completed frame.
  - Updated in the same cycle frame_done_out pulses; held otherwise.
  - Reset to 0; an aborted frame does not update it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Full frame:
  - Stimulus: WIDTH=4, HEIGHT=2 override; threshold 128; intensities 0,127,128,255,10,200,128,5 with sof on the first pixel.
  - Required: writes addr 0..7 with data 0,0,1,1,0,1,1,0.
  - Required: frame_done_out pulses once, with the addr-7 strobe.
  - With MASK_PIXEL_COUNT_EN: ones_count_out=4.
- Busy skip:
  - Stimulus: reader_busy_in=1 at sof.
  - Required: no wr_en_out for that frame; dropped_frames_out 0->1.
  - Stimulus: repeat 300 busy frames.
  - Required: dropped_frames_out saturates at 255.
- Gapped valid:
  - Stimulus: pixel_valid_in toggled 1,0,0,1,...
  - Required: addresses are still contiguous 0..N-1; wr_en_out is exactly one cycle per accepted pixel.
- Early sof:
  - Stimulus: sof after 5 pixels of an 8-pixel frame.
  - Required: next write at addr 0; no frame_done_out until 8 further pixels.
  - Required: threshold relatched (change threshold 128->0 gives all-1 data).
- Reset mid-frame:
  - Stimulus: rst_in=0 for one cycle after 3 pixels.
  - Required: all outputs 0; subsequent non-sof pixels ignored; next sof writes addr 0.
- Back-to-back:
  - Stimulus: sof on the cycle after frame_done_out.
  - Required: accepted; the second frame completes with its own single frame_done_out pulse.

Source files
------------

// File: rtl/mask_frame_writer.sv
// mask_frame_writer
//   Producer end of the binary mask frame buffer read by the edge finder.
//   Thresholds a streamed 8-bit intensity image and writes one mask bit per
//   pixel in row-major order (addr = y*WIDTH + x). A one-cycle frame_done_out
//   pulse, coincident with the last pixel's write strobe, triggers the reader.
//   Whole frames are skipped (and counted) while the reader reports busy.
//
// Ports
//   clk_in              system clock
//   rst_in              synchronous reset, active-low
//   pixel_valid_in      intensity_in valid this cycle
//   sof_in              start of frame, qualified by pixel_valid_in
//   intensity_in[7:0]   pixel intensity
//   threshold_in[7:0]   mask threshold, sampled at an accepted sof
//   reader_busy_in      downstream edge finder busy
//   wr_addr_out         frame buffer write address (held between writes)
//   wr_data_out         mask bit (held between writes)
//   wr_en_out           write strobe, one cycle after each accepted pixel
//   frame_done_out      one-cycle pulse with the last pixel's write strobe
//   busy_out            high while capturing a frame
//   dropped_frames_out  saturating count of skipped frames
//   ones_count_out      (MASK_PIXEL_COUNT_EN only) mask-1 pixels in the last
//                       completed frame
//
// Build option
//   MASK_PIXEL_COUNT_EN  adds ones_count_out and its accumulator.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for an sof; busy-at-sof frames are counted as dropped
// CAPTURE | writing pixels 1..WIDTH*HEIGHT-1 of the current frame
// DONE    | last write strobe + frame_done_out presented; back to IDLE

module mask_frame_writer #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pixel_valid_in,
  input  logic              sof_in,
  input  logic [7:0]        intensity_in,
  input  logic [7:0]        threshold_in,
  input  logic              reader_busy_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic              wr_data_out,
  output logic              wr_en_out,
  output logic              frame_done_out,
  output logic              busy_out,
  output logic [7:0]        dropped_frames_out
`ifdef MASK_PIXEL_COUNT_EN
  ,
  output logic [ADDR_W:0]   ones_count_out
`endif
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  // A one-pixel frame completes on its sof pixel.
  localparam logic SINGLE_PIXEL = (TOTAL == 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_count;
  logic [7:0]        r_thr;

  logic w_sof;
  logic w_bit_new;   // compare against the threshold being sampled now
  logic w_bit_cur;   // compare against the latched threshold
  logic w_last;

  assign w_sof     = pixel_valid_in && sof_in;
  assign w_bit_new = (intensity_in >= threshold_in);
  assign w_bit_cur = (intensity_in >= r_thr);
  assign w_last    = (r_count == LAST_ADDR);
  assign busy_out  = (r_state == S_CAPTURE);

`ifdef MASK_PIXEL_COUNT_EN
  logic [ADDR_W:0] r_ones_acc;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state            <= S_IDLE;
      r_count            <= '0;
      r_thr              <= '0;
      wr_addr_out        <= '0;
      wr_data_out        <= 1'b0;
      wr_en_out          <= 1'b0;
      frame_done_out     <= 1'b0;
      dropped_frames_out <= '0;
`ifdef MASK_PIXEL_COUNT_EN
      r_ones_acc         <= '0;
      ones_count_out     <= '0;
`endif
    end else begin
      wr_en_out      <= 1'b0;
      frame_done_out <= 1'b0;

      case (r_state)
        S_IDLE, S_CAPTURE: begin
          if (w_sof) begin
            if (reader_busy_in) begin
              // Skip the whole frame; a busy sof mid-capture also abandons
              // the partial frame so the reader never sees it completed.
              if (dropped_frames_out != 8'hFF)
                dropped_frames_out <= dropped_frames_out + 8'd1;
              r_state <= S_IDLE;
            end else begin
              r_thr          <= threshold_in;
              wr_addr_out    <= '0;
              wr_data_out    <= w_bit_new;
              wr_en_out      <= 1'b1;
              r_count        <= ADDR_W'(1);
              r_state        <= SINGLE_PIXEL ? S_DONE : S_CAPTURE;
              frame_done_out <= SINGLE_PIXEL;
`ifdef MASK_PIXEL_COUNT_EN
              r_ones_acc     <= (ADDR_W+1)'(w_bit_new);
              if (SINGLE_PIXEL)
                ones_count_out <= (ADDR_W+1)'(w_bit_new);
`endif
            end
          end else if (pixel_valid_in && (r_state == S_CAPTURE)) begin
            wr_addr_out <= r_count;
            wr_data_out <= w_bit_cur;
            wr_en_out   <= 1'b1;
`ifdef MASK_PIXEL_COUNT_EN
            r_ones_acc  <= r_ones_acc + (ADDR_W+1)'(w_bit_cur);
`endif
            if (w_last) begin
              r_state        <= S_DONE;
              frame_done_out <= 1'b1;
`ifdef MASK_PIXEL_COUNT_EN
              ones_count_out <= r_ones_acc + (ADDR_W+1)'(w_bit_cur);
`endif
            end else begin
              r_count <= r_count + ADDR_W'(1);
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_frame_writer.sv
module tb_mask_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = $clog2(W*H);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          pixel_valid_in;
  logic          sof_in;
  logic [7:0]    intensity_in;
  logic [7:0]    threshold_in;
  logic          reader_busy_in;
  logic [AW-1:0] wr_addr_out;
  logic          wr_data_out;
  logic          wr_en_out;
  logic          frame_done_out;
  logic          busy_out;
  logic [7:0]    dropped_frames_out;
`ifdef MASK_PIXEL_COUNT_EN
  logic [AW:0]   ones_count_out;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_in = ~clk_in;

  mask_frame_writer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .pixel_valid_in     (pixel_valid_in),
    .sof_in             (sof_in),
    .intensity_in       (intensity_in),
    .threshold_in       (threshold_in),
    .reader_busy_in     (reader_busy_in),
    .wr_addr_out        (wr_addr_out),
    .wr_data_out        (wr_data_out),
    .wr_en_out          (wr_en_out),
    .frame_done_out     (frame_done_out),
    .busy_out           (busy_out),
    .dropped_frames_out (dropped_frames_out)
`ifdef MASK_PIXEL_COUNT_EN
    ,
    .ones_count_out     (ones_count_out)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic s, input logic [7:0] inten,
                      input logic [7:0] thr, input logic busy,
                      input logic rst = 1'b1);
    rst_in         = rst;
    pixel_valid_in = v;
    sof_in         = s;
    intensity_in   = inten;
    threshold_in   = thr;
    reader_busy_in = busy;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wchk(input string tag, input int en, input int addr,
                      input int data, input int done);
    chk({tag, ".en"},   int'(wr_en_out),      en);
    chk({tag, ".addr"}, int'(wr_addr_out),    addr);
    chk({tag, ".data"}, int'(wr_data_out),    data);
    chk({tag, ".done"}, int'(frame_done_out), done);
  endtask

  logic [7:0] f1_int  [8] = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd10, 8'd200, 8'd128, 8'd5};
  logic       f1_bit  [8] = '{0, 0, 1, 1, 0, 1, 1, 0};
  logic [7:0] f2_int  [8] = '{8'd100, 8'd99, 8'd0, 8'd255, 8'd101, 8'd100, 8'd50, 8'd150};
  logic       f2_bit  [8] = '{1, 0, 0, 1, 1, 1, 0, 1};

  initial begin
    // Reset
    step(0, 0, 8'd0, 8'd0, 0, 0);
    step(0, 0, 8'd0, 8'd0, 0, 0);
    wchk("reset", 0, 0, 0, 0);
    chk("reset.busy", int'(busy_out), 0);
    chk("reset.drop", int'(dropped_frames_out), 0);
`ifdef MASK_PIXEL_COUNT_EN
    chk("reset.ones", int'(ones_count_out), 0);
`endif

    // Non-sof pixels in IDLE are ignored
    step(1, 0, 8'd200, 8'd128, 0);
    wchk("idle_nosof", 0, 0, 0, 0);

    // Full frame, threshold 128
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), f1_int[i], 8'd128, 0);
      wchk($sformatf("full%0d", i), 1, i, int'(f1_bit[i]), (i == 7) ? 1 : 0);
      chk($sformatf("full%0d.busy", i), int'(busy_out), (i < 7) ? 1 : 0);
    end
`ifdef MASK_PIXEL_COUNT_EN
    chk("full.ones", int'(ones_count_out), 4);
`endif
    step(0, 0, 8'd0, 8'd0, 0);
    wchk("full.after", 0, 7, 0, 0);

    // Back-to-back: sof on the cycle after frame_done_out, threshold 100
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), f2_int[i], 8'd100, 0);
      wchk($sformatf("b2b%0d", i), 1, i, int'(f2_bit[i]), (i == 7) ? 1 : 0);
    end
`ifdef MASK_PIXEL_COUNT_EN
    chk("b2b.ones", int'(ones_count_out), 5);
`endif
    step(0, 0, 8'd0, 8'd0, 0);
    wchk("b2b.after", 0, 7, 1, 0);

    // Gapped valid 1,0,0,...; intensities i*36 against 128
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), 8'(i * 36), 8'd128, 0);
      wchk($sformatf("gap%0d", i), 1, i, (i >= 4) ? 1 : 0, (i == 7) ? 1 : 0);
      step(0, 0, 8'd255, 8'd128, 0);
      wchk($sformatf("gap%0d.idle1", i), 0, i, (i >= 4) ? 1 : 0, 0);
      step(0, 0, 8'd255, 8'd128, 0);
      chk($sformatf("gap%0d.idle2.en", i), int'(wr_en_out), 0);
    end

    // Early sof after 5 pixels; threshold relatched 128 -> 0
    for (int i = 0; i < 5; i++) begin
      step(1, (i == 0), 8'd0, 8'd128, 0);
      wchk($sformatf("early%0d", i), 1, i, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), 8'd0, 8'd0, 0);
      wchk($sformatf("early_re%0d", i), 1, i, 1, (i == 7) ? 1 : 0);
    end
`ifdef MASK_PIXEL_COUNT_EN
    chk("early.ones", int'(ones_count_out), 8);
`endif
    step(0, 0, 8'd0, 8'd0, 0);

    // Busy at sof in IDLE: frame skipped, pixels ignored
    step(1, 1, 8'd255, 8'd0, 1);
    wchk("skip.sof", 0, 7, 1, 0);
    chk("skip.busy", int'(busy_out), 0);
    chk("skip.drop", int'(dropped_frames_out), 1);
    step(1, 0, 8'd255, 8'd0, 0);
    chk("skip.px.en", int'(wr_en_out), 0);

    // reader_busy ignored in CAPTURE, busy sof in CAPTURE aborts + counts
    step(1, 1, 8'd0, 8'd200, 0);
    wchk("abort.sof", 1, 0, 0, 0);
    step(1, 0, 8'd255, 8'd0, 1);
    wchk("abort.px_busy", 1, 1, 1, 0);
    step(1, 1, 8'd255, 8'd0, 1);
    chk("abort.en", int'(wr_en_out), 0);
    chk("abort.busy", int'(busy_out), 0);
    chk("abort.drop", int'(dropped_frames_out), 2);
    step(1, 0, 8'd255, 8'd0, 0);
    chk("abort.px.en", int'(wr_en_out), 0);
`ifdef MASK_PIXEL_COUNT_EN
    chk("abort.ones", int'(ones_count_out), 8);
`endif

    // Saturation: 300 dropped frames in total
    for (int i = 0; i < 252; i++) begin
      step(1, 1, 8'd0, 8'd0, 1);
      step(0, 0, 8'd0, 8'd0, 1);
    end
    chk("sat.254", int'(dropped_frames_out), 254);
    step(1, 1, 8'd0, 8'd0, 1);
    chk("sat.255", int'(dropped_frames_out), 255);
    for (int i = 0; i < 45; i++) begin
      step(1, 1, 8'd0, 8'd0, 1);
      chk($sformatf("sat.hold%0d.en", i), int'(wr_en_out), 0);
    end
    chk("sat.300", int'(dropped_frames_out), 255);

    // Reset mid-frame after 3 pixels
    for (int i = 0; i < 3; i++) begin
      step(1, (i == 0), 8'd200, 8'd128, 0);
      wchk($sformatf("rst_pre%0d", i), 1, i, 1, 0);
    end
    step(1, 0, 8'd200, 8'd128, 0, 0);
    wchk("rst_mid", 0, 0, 0, 0);
    chk("rst_mid.busy", int'(busy_out), 0);
    chk("rst_mid.drop", int'(dropped_frames_out), 0);
`ifdef MASK_PIXEL_COUNT_EN
    chk("rst_mid.ones", int'(ones_count_out), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 8'd200, 8'd128, 0);
      wchk($sformatf("rst_post%0d", i), 0, 0, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 0), 8'd200, 8'd128, 0);
      wchk($sformatf("rst_new%0d", i), 1, i, 1, (i == 7) ? 1 : 0);
    end
    step(0, 0, 8'd0, 8'd0, 0);
    chk("end.done", int'(frame_done_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
